instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   PC generation and IF/ID register directly upstream of instruction_memory
//   and downstream into the decoder. Drives the byte address, captures the
//   32-bit big-endian-assembled word, and hands {instr, pc} to decode over a
//   valid/ready handshake. Supports control-flow redirect (branch/jump) with
//   flush of the in-flight fetch.
// PARAMETERS
//   MEM_SIZE     128       bytes of instruction memory; power of 2, >= 8
//   AW           $clog2(MEM_SIZE)  address/PC width (derived, do not override)
//   RESET_PC     0         PC after reset; must be 4-byte aligned, < MEM_SIZE
//   NOP_INSTR    32'h00000013  value of id_instr when reset/flushed (addi x0,x0,0)
// PORTS
//   clk            in   1    clock; all state on posedge
//   rst            in   1    synchronous, active-high reset
//   fetch_en       in   1    1 = fetch allowed; 0 = PC frozen, no new valid
//   imem_addr      out  AW   byte address to instruction memory (= pc_reg)
//   imem_data      in   32   word returned by instruction memory (combinational)
//   redirect_valid in   1    1-cycle pulse: take redirect_pc as next PC
//   redirect_pc    in   AW   redirect target (byte address)
//   id_valid       out  1    id_instr/id_pc hold a live instruction
//   id_ready       in   1    decoder accepts this cycle when id_valid=1
//   id_instr       out  32   fetched instruction
//   id_pc          out  AW   byte address id_instr was fetched from
//   fetch_fault    out  1    sticky misaligned-redirect flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=1 at posedge): pc_reg<=RESET_PC, id_valid<=0, id_instr<=NOP_INSTR,
//     id_pc<=0, fetch_fault<=0. rst dominates all other inputs.
//   imem_addr = pc_reg combinationally; imem_data sampled same cycle.
//   advance = fetch_en & (~id_valid | id_ready). Priority per posedge:
//     1. redirect_valid: pc_reg<=redirect_pc; id_valid<=0; id_instr<=NOP_INSTR.
//        Overrides advance and an accepting handshake in the same cycle (the
//        accepted instr is consumed; nothing new is issued).
//     2. advance: id_instr<=imem_data; id_pc<=pc_reg; id_valid<=1;
//        pc_reg<=(pc_reg+4) mod MEM_SIZE (AW-bit wrap, MEM_SIZE-4 -> 0).
//     3. else if id_valid & id_ready (fetch_en=0): id_valid<=0, pc held.
//     4. else hold all state (stall: id_* stable while id_valid & ~id_ready).
//   Latency: word at PC p appears on id_instr 1 cycle after imem_addr=p.
//   Throughput: 1 instr/cycle with id_ready held high.
//   Handshake: transfer when id_valid & id_ready at posedge; id_instr/id_pc
//     must not change while id_valid=1 and id_ready=0 unless redirect.
//   Redirect during stall: pending instr dropped, fetch resumes at target
//     next cycle; first post-redirect id_valid two posedges after pulse.
//   rst asserted mid-stream: all in-flight state discarded, restart at RESET_PC.
// CONFIGURATION
//   FETCH_MISALIGN_TRAP_EN defined:
//     redirect with redirect_pc[1:0]!=0 sets fetch_fault<=1 (sticky until rst),
//     flushes id_valid to 0, and freezes fetch (advance forced 0) until rst.
//   Not defined: redirect_pc[1:0] forced to 2'b00; fetch_fault tied 0.
// TESTING
//   1. rst 2 cycles, fetch_en=1, id_ready=1 -> id_pc 0,4,8 with id_instr
//      32'hffc4a303, 32'h00832383, 32'h0064a423 on consecutive cycles.
//   2. id_ready=0 for 3 cycles at id_pc=4 -> id_instr holds 32'h00832383,
//      imem_addr holds 8; release -> id_pc=8 next cycle, no skip/duplicate.
//   3. redirect_valid pulse, redirect_pc=8, while id_pc=0 stalled -> id_valid=0
//      next cycle, then id_pc=8, id_instr=32'h0064a423.
//   4. Free-run to pc=MEM_SIZE-4 (124) -> next imem_addr=0, id_pc wraps 124->0.
//   5. rst asserted while id_valid=1 stalled -> next cycle id_valid=0,
//      id_instr=32'h00000013, imem_addr=RESET_PC.
//   6. With FETCH_MISALIGN_TRAP_EN, redirect_pc=6 -> fetch_fault=1, id_valid
//      stays 0 for 10 cycles; without macro -> fetches from 4 (32'h00832383).

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction-memory port, redirect input and IF/ID handshake.
// master = fetch unit, slave = memory/decoder/control environment.
interface instruction_fetch_if #(
    parameter int unsigned AW = 7
);
    logic          fetch_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_instr;
    logic [AW-1:0] id_pc;
    logic          fetch_fault;

    modport master (
        input  fetch_en, imem_data, redirect_valid, redirect_pc, id_ready,
        output imem_addr, id_valid, id_instr, id_pc, fetch_fault
    );

    modport slave (
        output fetch_en, imem_data, redirect_valid, redirect_pc, id_ready,
        input  imem_addr, id_valid, id_instr, id_pc, fetch_fault
    );
endinterface

// File: rtl/instruction_fetch.sv
// PC generation and IF/ID register with redirect/flush and valid/ready hand-off to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect sets sticky fetch_fault and freezes fetch.
module instruction_fetch #(
    parameter int unsigned MEM_SIZE  = 128,
    parameter int unsigned RESET_PC  = 0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                i_clk,
    input  logic                i_rst,
    instruction_fetch_if.master bus
);
    localparam int unsigned AW = $clog2(MEM_SIZE);
    localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_PC);

    logic [AW-1:0] r_pc;
    logic          r_id_valid;
    logic [31:0]   r_id_instr;
    logic [AW-1:0] r_id_pc;
    logic          r_fault;

    logic [AW-1:0] w_pc_next;
    logic          w_id_valid_next;
    logic [31:0]   w_id_instr_next;
    logic [AW-1:0] w_id_pc_next;
    logic          w_fault_next;

    logic [AW-1:0] w_redirect_pc;
    logic          w_redirect_misaligned;
    logic          w_frozen;
    logic          w_advance;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_redirect_pc         = bus.redirect_pc;
    assign w_redirect_misaligned = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
    assign w_frozen              = r_fault;
`else
    // Low address bits dropped so the PC can never become misaligned.
    assign w_redirect_pc         = bus.redirect_pc & ~AW'(3);
    assign w_redirect_misaligned = 1'b0;
    assign w_frozen              = 1'b0;
`endif

    assign w_advance = bus.fetch_en & ~w_frozen & (~r_id_valid | bus.id_ready);

    always_comb begin
        w_pc_next       = r_pc;
        w_id_valid_next = r_id_valid;
        w_id_instr_next = r_id_instr;
        w_id_pc_next    = r_id_pc;
        w_fault_next    = r_fault;
        if (bus.redirect_valid) begin
            // Redirect wins over advance; an instruction accepted this cycle is still consumed.
            w_pc_next       = w_redirect_pc;
            w_id_valid_next = 1'b0;
            w_id_instr_next = NOP_INSTR;
            w_fault_next    = r_fault | w_redirect_misaligned;
        end else if (w_advance) begin
            w_pc_next       = r_pc + AW'(4);
            w_id_valid_next = 1'b1;
            w_id_instr_next = bus.imem_data;
            w_id_pc_next    = r_pc;
        end else if (r_id_valid && bus.id_ready) begin
            w_id_valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_ADDR;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_id_valid <= w_id_valid_next;
            r_id_instr <= w_id_instr_next;
            r_id_pc    <= w_id_pc_next;
            r_fault    <= w_fault_next;
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.id_valid    = r_id_valid;
    assign bus.id_instr    = r_id_instr;
    assign bus.id_pc       = r_id_pc;
    assign bus.fetch_fault = r_fault;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: every-cycle comparison against a behavioural
// model plus hand-computed literal expectations for each scenario.
module tb_instruction_fetch;
    localparam int unsigned MEM_SIZE = 128;
    localparam int unsigned AW       = 7;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [31:0] mem [MEM_SIZE/4];

    instruction_fetch_if #(.AW(AW)) bus ();

    instruction_fetch #(
        .MEM_SIZE (MEM_SIZE),
        .RESET_PC (0),
        .NOP_INSTR(NOP)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr[AW-1:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected architectural state derived from the handshake rules.
    int          m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    int          m_idpc;
    bit          m_fault;
    bit          m_known;

    initial m_known = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc    <= 0;
            m_valid <= 1'b0;
            m_instr <= NOP;
            m_idpc  <= 0;
            m_fault <= 1'b0;
            m_known <= 1'b1;
        end else if (bus.redirect_valid) begin
            m_valid <= 1'b0;
            m_instr <= NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc <= int'(bus.redirect_pc);
            if (int'(bus.redirect_pc) % 4 != 0) m_fault <= 1'b1;
`else
            m_pc <= (int'(bus.redirect_pc) / 4) * 4;
`endif
        end else if (bus.fetch_en && !m_fault && (!m_valid || bus.id_ready)) begin
            m_instr <= mem[m_pc / 4];
            m_idpc  <= m_pc;
            m_valid <= 1'b1;
            m_pc    <= (m_pc + 4) % MEM_SIZE;
        end else if (m_valid && bus.id_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("model.imem_addr", 32'(bus.imem_addr), 32'(m_pc));
            check("model.id_valid", 32'(bus.id_valid), 32'(m_valid));
            check("model.id_instr", bus.id_instr, m_instr);
            check("model.id_pc", 32'(bus.id_pc), 32'(m_idpc));
            check("model.fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < int'(MEM_SIZE / 4); i++) mem[i] = 32'hA000_0000 | (i << 8) | i;
        mem[0] = 32'hffc4a303;
        mem[1] = 32'h00832383;
        mem[2] = 32'h0064a423;

        rst                = 1'b1;
        bus.fetch_en       = 1'b1;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // 1: reset then free-run
        tick();
        tick();
        check("rst.id_valid", 32'(bus.id_valid), 32'd0);
        check("rst.id_instr", bus.id_instr, NOP);
        check("rst.imem_addr", 32'(bus.imem_addr), 32'd0);
        check("rst.fault", 32'(bus.fetch_fault), 32'd0);
        rst = 1'b0;
        tick();
        check("run.id_pc0", 32'(bus.id_pc), 32'd0);
        check("run.instr0", bus.id_instr, 32'hffc4a303);
        check("run.imem_addr4", 32'(bus.imem_addr), 32'd4);
        tick();
        check("run.id_pc4", 32'(bus.id_pc), 32'd4);
        check("run.instr4", bus.id_instr, 32'h00832383);

        // 2: stall at id_pc=4
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.instr", bus.id_instr, 32'h00832383);
            check("stall.imem_addr", 32'(bus.imem_addr), 32'd8);
            check("stall.valid", 32'(bus.id_valid), 32'd1);
        end
        bus.id_ready = 1'b1;
        tick();
        check("release.id_pc", 32'(bus.id_pc), 32'd8);
        check("release.instr", bus.id_instr, 32'h0064a423);

        // 3: redirect while stalled at id_pc=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.id_ready = 1'b0;
        tick();
        check("redir.pre_pc", 32'(bus.id_pc), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(8);
        tick();
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b1;
        check("redir.flush_valid", 32'(bus.id_valid), 32'd0);
        check("redir.imem_addr", 32'(bus.imem_addr), 32'd8);
        tick();
        check("redir.valid", 32'(bus.id_valid), 32'd1);
        check("redir.id_pc", 32'(bus.id_pc), 32'd8);
        check("redir.instr", bus.id_instr, 32'h0064a423);

        // 4: wrap 124 -> 0
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.imem_addr == AW'(124)) found = 1'b1;
            else tick();
        end
        check("wrap.reached", 32'(found), 32'd1);
        tick();
        check("wrap.id_pc124", 32'(bus.id_pc), 32'd124);
        check("wrap.instr124", bus.id_instr, 32'hA0001F1F);
        check("wrap.imem_addr0", 32'(bus.imem_addr), 32'd0);
        tick();
        check("wrap.id_pc0", 32'(bus.id_pc), 32'd0);
        check("wrap.instr0", bus.id_instr, 32'hffc4a303);

        // fetch_en=0 with accepting decoder: drain, PC held
        bus.fetch_en = 1'b0;
        tick();
        check("noen.valid", 32'(bus.id_valid), 32'd0);
        check("noen.imem_addr", 32'(bus.imem_addr), 32'd4);
        tick();
        check("noen.hold", 32'(bus.imem_addr), 32'd4);
        bus.fetch_en = 1'b1;

        // 5: reset while stalled
        bus.id_ready = 1'b0;
        tick();
        check("rst2.pre_valid", 32'(bus.id_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.id_ready = 1'b1;
        check("rst2.valid", 32'(bus.id_valid), 32'd0);
        check("rst2.instr", bus.id_instr, NOP);
        check("rst2.imem_addr", 32'(bus.imem_addr), 32'd0);

        // 6: misaligned redirect
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(6);
        tick();
        bus.redirect_valid = 1'b0;
        check("mis.flush_valid", 32'(bus.id_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis.fault", 32'(bus.fetch_fault), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mis.frozen_valid", 32'(bus.id_valid), 32'd0);
            check("mis.fault_sticky", 32'(bus.fetch_fault), 32'd1);
        end
`else
        check("mis.fault", 32'(bus.fetch_fault), 32'd0);
        check("mis.imem_addr", 32'(bus.imem_addr), 32'd4);
        tick();
        check("mis.id_pc", 32'(bus.id_pc), 32'd4);
        check("mis.instr", bus.id_instr, 32'h00832383);
`endif
        tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
